// File: rtl/uart_pkg.sv
// Shared types and parity helper for the UART FIFO transceiver.
// Both FSM state sets and the parity mode encodings live here.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

   // Callers zero-extend narrower words; the padding does not change the XOR.
   function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LW'(DEPTH));
   assign do_pop  = rd_en & ~empty;
   assign do_push = wr_en & (~full | do_pop);
   assign rd_data = mem[rd_ptr_q];
   assign level   = level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      level_q <= level_q + LW'(1);
         else if (!do_push && do_pop) level_q <= level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_fifo_xcvr.sv
// UART transceiver with TX/RX FIFOs, configurable framing and sticky RX error flags.
// Fabric side uses valid/ready streams; line side is rxd/txd in the same clock domain.
module uart_fifo_xcvr
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   input  logic                          err_clear,
   output logic                          rx_overrun,
   output logic                          rx_parity_err,
   output logic                          rx_frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   input  logic                          uart_rxd,
   output logic                          uart_txd
);

   localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
   localparam int unsigned   BW        = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CntLast   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CntHalf   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BitLast   = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] StopLast  = BW'(STOP_BITS - 1);
   localparam bit            HasParity = (PARITY != PAR_NONE);

   // ---------------- TX ----------------
   logic                 tx_fifo_full, tx_fifo_empty, tx_pop, tx_bit_end, tx_stop_end;
   logic [DATA_BITS-1:0] tx_fifo_data, tx_shift_q, tx_shift_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic                 tx_par_q, tx_par_d;
   tx_state_e            tx_state_q, tx_state_d;

   assign tx_ready = ~tx_fifo_full;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .wr_en   (tx_valid & tx_ready),
      .wr_data (tx_data),
      .rd_en   (tx_pop),
      .rd_data (tx_fifo_data),
      .full    (tx_fifo_full),
      .empty   (tx_fifo_empty),
      .level   (tx_level)
   );

   assign tx_bit_end  = (tx_cnt_q == CntLast);
   assign tx_stop_end = (tx_state_q == TxStop) && tx_bit_end && (tx_bit_q == StopLast);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      // A pop from IDLE or the final stop clock chains straight into a start bit.
      if (tx_pop) begin
         tx_state_d = TxStart;
         tx_cnt_d   = '0;
         tx_shift_d = tx_fifo_data;
         tx_par_d   = parity_bit(9'(tx_fifo_data), PARITY);
      end else begin
         unique case (tx_state_q)
            TxIdle:   tx_cnt_d = '0;
            TxStart:  if (tx_bit_end) begin
                         tx_state_d = TxData;
                         tx_bit_d   = '0;
                      end
            TxData:   if (tx_bit_end) begin
                         tx_shift_d = tx_shift_q >> 1;
                         tx_bit_d   = tx_bit_q + BW'(1);
                         if (tx_bit_q == BitLast) begin
                            tx_state_d = HasParity ? TxParity : TxStop;
                            tx_bit_d   = '0;
                         end
                      end
            TxParity: if (tx_bit_end) tx_state_d = TxStop;
            TxStop:   if (tx_bit_end) begin
                         if (tx_bit_q == StopLast) tx_state_d = TxIdle;
                         else                      tx_bit_d   = tx_bit_q + BW'(1);
                      end
            default:  tx_state_d = TxIdle;
         endcase
      end
   end

   always_comb begin
      tx_pop   = 1'b0;
      uart_txd = 1'b1;
      unique case (tx_state_q)
         TxIdle:   tx_pop   = ~tx_fifo_empty;
         TxStart:  uart_txd = 1'b0;
         TxData:   uart_txd = tx_shift_q[0];
         TxParity: uart_txd = tx_par_q;
         TxStop:   tx_pop   = tx_stop_end & ~tx_fifo_empty;
         default:  ;
      endcase
   end

   // ---------------- RX ----------------
   logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_par_bad_q, rx_par_bad_d, rx_push_q, rx_push_d;
   logic                 rx_fifo_full, rx_fifo_empty, frame_set, overrun_set, parity_set;
   rx_state_e            rx_state_q, rx_state_d;

   assign rx_valid = ~rx_fifo_empty;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .wr_en   (rx_push_q),
      .wr_data (rx_shift_q),
      .rd_en   (rx_ready),
      .rd_data (rx_data),
      .full    (rx_fifo_full),
      .empty   (rx_fifo_empty),
      .level   (rx_level)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rxd_meta_q   <= 1'b1;
         rxd_sync_q   <= 1'b1;
         rxd_prev_q   <= 1'b1;
         rx_state_q   <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_bad_q <= 1'b0;
         rx_push_q    <= 1'b0;
      end else begin
         rxd_meta_q   <= uart_rxd;
         rxd_sync_q   <= rxd_meta_q;
         rxd_prev_q   <= rxd_sync_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_bad_q <= rx_par_bad_d;
         rx_push_q    <= rx_push_d;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q + CW'(1);
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_bad_d = rx_par_bad_q;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rxd_prev_q && !rxd_sync_q) rx_state_d = RxStart;
         end
         RxStart: if (rx_cnt_q == CntHalf) begin
            // Line back high at mid start bit is a glitch, not a frame.
            rx_cnt_d     = '0;
            rx_bit_d     = '0;
            rx_par_bad_d = 1'b0;
            rx_state_d   = rxd_sync_q ? RxIdle : RxData;
         end
         RxData: if (rx_cnt_q == CntLast) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_d   = rx_bit_q + BW'(1);
            if (rx_bit_q == BitLast) rx_state_d = HasParity ? RxParity : RxStop;
         end
         RxParity: if (rx_cnt_q == CntLast) begin
            rx_cnt_d     = '0;
            rx_par_bad_d = rxd_sync_q != parity_bit(9'(rx_shift_q), PARITY);
            rx_state_d   = RxStop;
         end
         RxStop: if (rx_cnt_q == CntLast) begin
            rx_cnt_d   = '0;
            rx_state_d = rxd_sync_q ? RxIdle : RxWaitHigh;
         end
         RxWaitHigh: begin
            rx_cnt_d = '0;
            if (rxd_sync_q) rx_state_d = RxIdle;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      rx_push_d = 1'b0;
      frame_set = 1'b0;
      if (rx_state_q == RxStop && rx_cnt_q == CntLast) begin
         rx_push_d = rxd_sync_q;
         frame_set = ~rxd_sync_q;
      end
   end

   assign overrun_set = rx_push_q & rx_fifo_full & ~(rx_valid & rx_ready);
   assign parity_set  = rx_push_q & rx_par_bad_q;

   // A new error wins over a simultaneous clear.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rx_overrun    <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_overrun    <= (rx_overrun    & ~err_clear) | overrun_set;
         rx_parity_err <= (rx_parity_err & ~err_clear) | parity_set;
         rx_frame_err  <= (rx_frame_err  & ~err_clear) | frame_set;
      end
   end

endmodule
